// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit carry-lookahead nibble per clock, LSB nibble first.
// Optional signed-overflow output enabled by defining NSA_OVERFLOW_EN.
module nibble_serial_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] din1,
   input  logic [WIDTH-1:0] din2,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] dout,
   output logic             cout
`ifdef NSA_OVERFLOW_EN
  ,output logic             ovf
`endif
);

   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sr, a_nx;
   logic [WIDTH-1:0] b_sr, b_nx;
   logic [WIDTH-1:0] res_r, res_nx;
   logic             carry_r, carry_nx;
   logic [CW-1:0]    nib_cnt, nib_cnt_nx;
   logic             in_ready_r, in_ready_nx;
   logic             out_valid_r, out_valid_nx;
`ifdef NSA_OVERFLOW_EN
   logic             a_msb, a_msb_nx;
   logic             b_msb, b_msb_nx;
   logic             ovf_r, ovf_nx;
`endif

   // 4-bit carry-lookahead slice on the low nibbles of the operand shifters
   logic [3:0] g, p, c, slice_sum;
   logic       slice_cout;

   always_comb begin
      g    = a_sr[3:0] & b_sr[3:0];
      p    = a_sr[3:0] ^ b_sr[3:0];
      c[0] = carry_r;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      slice_cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c[0]);
      slice_sum  = p ^ c;
   end

   // next-state and datapath update
   always_comb begin
      state_nx     = state;
      a_nx         = a_sr;
      b_nx         = b_sr;
      res_nx       = res_r;
      carry_nx     = carry_r;
      nib_cnt_nx   = nib_cnt;
      in_ready_nx  = 1'b0;
      out_valid_nx = 1'b0;
`ifdef NSA_OVERFLOW_EN
      a_msb_nx     = a_msb;
      b_msb_nx     = b_msb;
      ovf_nx       = 1'b0;
`endif
      case (state)
         IDLE: begin
            in_ready_nx = 1'b1;
            if (in_valid && in_ready_r) begin
               a_nx        = din1;
               b_nx        = din2;
               carry_nx    = cin;
               nib_cnt_nx  = '0;
               in_ready_nx = 1'b0;
               state_nx    = RUN;
`ifdef NSA_OVERFLOW_EN
               a_msb_nx    = din1[WIDTH-1];
               b_msb_nx    = din2[WIDTH-1];
`endif
            end
         end
         RUN: begin
            a_nx       = a_sr >> 4;
            b_nx       = b_sr >> 4;
            res_nx     = (res_r >> 4) | (WIDTH'(slice_sum) << (WIDTH - 4));
            carry_nx   = slice_cout;
            nib_cnt_nx = nib_cnt + CW'(1);
            if (nib_cnt == CW'(NIB - 1)) begin
               state_nx     = DONE;
               out_valid_nx = 1'b1;
`ifdef NSA_OVERFLOW_EN
               // the final slice sum MSB is the result MSB
               ovf_nx       = (a_msb == b_msb) && (slice_sum[3] != a_msb);
`endif
            end
         end
         DONE: begin
            out_valid_nx = 1'b1;
`ifdef NSA_OVERFLOW_EN
            ovf_nx       = ovf_r;
`endif
            if (out_ready) begin
               state_nx     = IDLE;
               out_valid_nx = 1'b0;
               in_ready_nx  = 1'b1;
`ifdef NSA_OVERFLOW_EN
               ovf_nx       = 1'b0;
`endif
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         a_sr        <= '0;
         b_sr        <= '0;
         res_r       <= '0;
         carry_r     <= 1'b0;
         nib_cnt     <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
`ifdef NSA_OVERFLOW_EN
         a_msb       <= 1'b0;
         b_msb       <= 1'b0;
         ovf_r       <= 1'b0;
`endif
      end else begin
         state       <= state_nx;
         a_sr        <= a_nx;
         b_sr        <= b_nx;
         res_r       <= res_nx;
         carry_r     <= carry_nx;
         nib_cnt     <= nib_cnt_nx;
         in_ready_r  <= in_ready_nx;
         out_valid_r <= out_valid_nx;
`ifdef NSA_OVERFLOW_EN
         a_msb       <= a_msb_nx;
         b_msb       <= b_msb_nx;
         ovf_r       <= ovf_nx;
`endif
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign dout      = res_r;
   assign cout      = carry_r;
`ifdef NSA_OVERFLOW_EN
   assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16, plus WIDTH=4 when NSA_OVERFLOW_EN is defined).
module tb_nibble_serial_adder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] din1;
   logic [15:0] din2;
   logic        cin;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] dout;
   logic        cout;
`ifdef NSA_OVERFLOW_EN
   logic        ovf;
   logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, ovf4;
   logic [3:0]  din1_4, din2_4, dout4;
`endif

   int errors = 0;
   int checks = 0;

   nibble_serial_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .din1(din1), .din2(din2), .cin(cin),
      .out_valid(out_valid), .out_ready(out_ready),
      .dout(dout), .cout(cout)
`ifdef NSA_OVERFLOW_EN
     ,.ovf(ovf)
`endif
   );

`ifdef NSA_OVERFLOW_EN
   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .din1(din1_4), .din2(din2_4), .cin(cin4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .dout(dout4), .cout(cout4), .ovf(ovf4)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // accept one operand pair, check 4-cycle latency, result and handshake back to IDLE
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] ed, input logic ec, input logic eo, input string tag);
      din1 = a; din2 = b; cin = c; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
      repeat (3) tick();
      check({tag, " out_valid early"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " dout"}, 32'(dout), 32'(ed));
      check({tag, " cout"}, 32'(cout), 32'(ec));
`ifdef NSA_OVERFLOW_EN
      check({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
      if (eo) begin end
`endif
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      din1 = '0; din2 = '0; cin = 1'b0;
`ifdef NSA_OVERFLOW_EN
      in_valid4 = 1'b0; out_ready4 = 1'b0; din1_4 = '0; din2_4 = '0; cin4 = 1'b0;
`endif
      tick();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("reset in_ready", 32'(in_ready), 32'd0);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset dout", 32'(dout), 32'd0);
      check("reset cout", 32'(cout), 32'd0);
      rst = 1'b0;
      tick();
      check("post-reset in_ready", 32'(in_ready), 32'd1);

      do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, "add1234");
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "rippleFFFF");
      do_op(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, "cin_ripple");

      // backpressure: result held while new operands wait
      din1 = 16'hAB00; din2 = 16'h00CD; cin = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      din1 = 16'h1111; din2 = 16'h2222; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp dout", 32'(dout), 32'h0000ABCD);
         check("bp in_ready", 32'(in_ready), 32'd0);
         check("bp out_valid", 32'(out_valid), 32'd1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp release in_ready", 32'(in_ready), 32'd1);
      check("bp release out_valid", 32'(out_valid), 32'd0);

      // reset after two RUN cycles
      din1 = 16'h1234; din2 = 16'h1111; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
      check("midrun rst in_ready", 32'(in_ready), 32'd0);
      check("midrun rst out_valid", 32'(out_valid), 32'd0);
      check("midrun rst dout", 32'(dout), 32'd0);
      rst = 1'b0;
      tick();
      check("midrun post in_ready", 32'(in_ready), 32'd1);
      repeat (4) tick();
      check("midrun no out_valid", 32'(out_valid), 32'd0);
      do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "after_rst");

`ifdef NSA_OVERFLOW_EN
      do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
      do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_neg");
      do_op(16'h0003, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 1'b0, "no_ovf");

      check("w4 in_ready", 32'(in_ready4), 32'd1);
      din1_4 = 4'h7; din2_4 = 4'h1; cin4 = 1'b0; in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      check("w4 out_valid early", 32'(out_valid4), 32'd0);
      tick();
      check("w4 out_valid", 32'(out_valid4), 32'd1);
      check("w4 dout", 32'(dout4), 32'h8);
      check("w4 cout", 32'(cout4), 32'd0);
      check("w4 ovf", 32'(ovf4), 32'd1);
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
      check("w4 ovf clear", 32'(ovf4), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
